// File: rtl/vga_axil_if_if.sv
// AXI4-Lite bus bundle between the VGA register-path master engine and a slave.
interface vga_axil_if_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [2:0]              awprot;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [2:0]              arprot;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/vga_axil_if.sv
// AXI4-Lite single-outstanding master: turns one-shot write/read commands
// into AW/W/B or AR/R handshakes and returns the response code and read data.
//
// state   | meaning
// IDLE    | cmd_ready high, waiting for a command
// WR_REQ  | AW and W offered, each retires on its own handshake
// WR_RESP | bready high, waiting for B
// RD_REQ  | AR offered
// RD_RESP | rready high, waiting for R
module vga_axil_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  output logic [1:0]            rsp_resp,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  vga_axil_if_if.master         axil
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_RESP = 3'd2,
    RD_REQ  = 3'd3,
    RD_RESP = 3'd4
  } state_t;

  state_t state, state_nxt;

  logic                  awvalid_q, wvalid_q, arvalid_q;
  logic [ADDR_WIDTH-1:0] awaddr_q, araddr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  accept;
  logic                  aw_done, w_done;

  assign accept  = cmd_valid && (state == IDLE);
  // A channel counts as done once its valid has dropped or is retiring this edge.
  assign aw_done = !awvalid_q || axil.awready;
  assign w_done  = !wvalid_q || axil.wready;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (cmd_valid) state_nxt = cmd_write ? WR_REQ : RD_REQ;
      WR_REQ:  if (aw_done && w_done) state_nxt = WR_RESP;
      WR_RESP: if (axil.bvalid) state_nxt = IDLE;
      RD_REQ:  if (arvalid_q && axil.arready) state_nxt = RD_RESP;
      RD_RESP: if (axil.rvalid) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      arvalid_q <= 1'b0;
      awaddr_q  <= '0;
      araddr_q  <= '0;
      wdata_q   <= '0;
      rsp_valid <= 1'b0;
      rsp_resp  <= 2'b00;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= 1'b0;
      if (awvalid_q && axil.awready) awvalid_q <= 1'b0;
      if (wvalid_q && axil.wready)   wvalid_q  <= 1'b0;
      if (arvalid_q && axil.arready) arvalid_q <= 1'b0;
      if (accept) begin
        if (cmd_write) begin
          awvalid_q <= 1'b1;
          wvalid_q  <= 1'b1;
          awaddr_q  <= cmd_addr;
          wdata_q   <= cmd_wdata;
        end else begin
          arvalid_q <= 1'b1;
          araddr_q  <= cmd_addr;
        end
      end
      if (state == WR_RESP && axil.bvalid) begin
        rsp_valid <= 1'b1;
        rsp_resp  <= axil.bresp;
      end
      if (state == RD_RESP && axil.rvalid) begin
        rsp_valid <= 1'b1;
        rsp_resp  <= axil.rresp;
        rsp_rdata <= axil.rdata;
      end
    end
  end

  assign cmd_ready    = (state == IDLE);
  assign axil.awaddr  = awaddr_q;
  assign axil.awprot  = 3'b000;
  assign axil.awvalid = awvalid_q;
  assign axil.wdata   = wdata_q;
  assign axil.wstrb   = '1;
  assign axil.wvalid  = wvalid_q;
  assign axil.bready  = (state == WR_RESP);
  assign axil.araddr  = araddr_q;
  assign axil.arprot  = 3'b000;
  assign axil.arvalid = arvalid_q;
  assign axil.rready  = (state == RD_RESP);

endmodule

// File: tb/tb_vga_axil_if.sv
// Directed bench for vga_axil_if with a configurable-latency AXI4-Lite slave model.
module tb_vga_axil_if;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          arst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic          cmd_ready;
  logic          rsp_valid;
  logic [1:0]    rsp_resp;
  logic [DW-1:0] rsp_rdata;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  vga_axil_if_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  vga_axil_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .arst_n    (arst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_resp  (rsp_resp),
    .rsp_rdata (rsp_rdata),
    .axil      (bus)
  );

  // slave configuration
  int          aw_delay = 0, w_delay = 0, ar_delay = 0, b_delay = 0, r_delay = 0;
  logic [1:0]  b_code = 2'd0, r_code = 2'd0;
  logic [31:0] r_fixed = 32'hDEAD_BEEF;

  // slave state
  int          aw_cnt = 0, w_cnt = 0, ar_cnt = 0, b_cnt = 0, r_cnt = 0;
  bit          aw_got = 0, w_got = 0, ar_got = 0, b_taken = 0, r_taken = 0;
  logic [31:0] sl_addr, sl_data, sl_raddr;
  logic [31:0] mem [logic [31:0]];

  // monitor counters
  int          n_acc = 0, n_aw = 0, n_w = 0, n_ar = 0, n_b = 0, n_r = 0, n_rsp = 0;
  int          aw_cyc = 0, w_cyc = 0, bad_bready = 0;
  bit          acc_rsp = 0;
  logic [31:0] last_awaddr = '0, last_wdata = '0, last_araddr = '0;
  logic [3:0]  last_wstrb = '0;
  logic [2:0]  last_awprot = '0, last_arprot = '0;

  always @(posedge clk) begin
    if (arst_n) begin
      if (cmd_valid && cmd_ready) begin n_acc++; acc_rsp = rsp_valid; end
      if (bus.awvalid) aw_cyc++;
      if (bus.wvalid) w_cyc++;
      if (bus.bready && (bus.awvalid || bus.wvalid)) bad_bready++;
      if (rsp_valid) n_rsp++;
      if (bus.awvalid && bus.awready) begin
        n_aw++; aw_got = 1; aw_cnt = 0; sl_addr = bus.awaddr;
        last_awaddr = bus.awaddr; last_awprot = bus.awprot;
      end
      if (bus.wvalid && bus.wready) begin
        n_w++; w_got = 1; w_cnt = 0; sl_data = bus.wdata;
        last_wdata = bus.wdata; last_wstrb = bus.wstrb;
      end
      if (bus.bvalid && bus.bready) begin n_b++; b_taken = 1; end
      if (bus.arvalid && bus.arready) begin
        n_ar++; ar_got = 1; ar_cnt = 0; sl_raddr = bus.araddr;
        last_araddr = bus.araddr; last_arprot = bus.arprot;
      end
      if (bus.rvalid && bus.rready) begin n_r++; r_taken = 1; end
    end
  end

  always @(negedge clk) begin
    if (!arst_n) begin
      bus.awready = 0; bus.wready = 0; bus.arready = 0;
      bus.bvalid = 0; bus.bresp = 0; bus.rvalid = 0; bus.rresp = 0; bus.rdata = 0;
      aw_got = 0; w_got = 0; ar_got = 0; b_taken = 0; r_taken = 0;
      aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
    end else begin
      bus.awready = bus.awvalid && (aw_cnt >= aw_delay);
      if (bus.awvalid) aw_cnt++;
      bus.wready = bus.wvalid && (w_cnt >= w_delay);
      if (bus.wvalid) w_cnt++;
      bus.arready = bus.arvalid && (ar_cnt >= ar_delay);
      if (bus.arvalid) ar_cnt++;
      if (b_taken) begin bus.bvalid = 0; b_taken = 0; end
      if (aw_got && w_got && !bus.bvalid) begin
        if (b_cnt >= b_delay) begin
          bus.bvalid = 1; bus.bresp = b_code; mem[sl_addr] = sl_data;
          aw_got = 0; w_got = 0; b_cnt = 0;
        end else b_cnt++;
      end
      if (r_taken) begin bus.rvalid = 0; r_taken = 0; end
      if (ar_got && !bus.rvalid) begin
        if (r_cnt >= r_delay) begin
          bus.rvalid = 1; bus.rresp = r_code;
          bus.rdata = mem.exists(sl_raddr) ? mem[sl_raddr] : r_fixed;
          ar_got = 0; r_cnt = 0;
        end else r_cnt++;
      end
    end
  end

  // Issues one command, returns latency in cycles from accept edge to rsp_valid.
  task automatic do_cmd(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                        output int lat, output logic [1:0] resp, output logic [31:0] rd,
                        output bit ok);
    int k;
    ok = 0; lat = 0; resp = 'x; rd = 'x;
    @(negedge clk);
    cmd_valid = 1; cmd_write = wr; cmd_addr = addr; cmd_wdata = data;
    k = 0;
    while (!cmd_ready && k < 50) begin @(negedge clk); k++; end
    @(posedge clk);
    for (int i = 1; i <= 50; i++) begin
      @(negedge clk);
      if (i == 1) cmd_valid = 0;
      #1;
      if (rsp_valid) begin lat = i; resp = rsp_resp; rd = rsp_rdata; ok = 1; break; end
    end
    total++;
    if (!ok) begin bad++; $display("FAIL timeout: no rsp_valid within 50 cycles (addr %h)", addr); end
  endtask

  task automatic settle();
    repeat (3) @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk); #1;
    total++;
    if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready); end
    total++;
    if ({bus.awvalid, bus.wvalid, bus.arvalid, bus.bready, bus.rready, rsp_valid} !== 6'b0) begin
      bad++; $display("FAIL reset_valids: got %b want 000000",
        {bus.awvalid, bus.wvalid, bus.arvalid, bus.bready, bus.rready, rsp_valid});
    end
    total++;
    if (rsp_resp !== 2'b00) begin bad++; $display("FAIL reset_rsp_resp: got %0d want 0", rsp_resp); end
    total++;
    if (rsp_rdata !== 32'h0) begin bad++; $display("FAIL reset_rsp_rdata: got %h want 0", rsp_rdata); end
    total++;
    if ({bus.awaddr, bus.wdata, bus.araddr} !== 96'h0) begin
      bad++; $display("FAIL reset_addr_data: awaddr %h wdata %h araddr %h want 0", bus.awaddr, bus.wdata, bus.araddr);
    end
  endtask

  task automatic test_write_basic();
    int lat, awc0, wc0, rsp0; logic [1:0] resp; logic [31:0] rd; bit ok;
    awc0 = aw_cyc; wc0 = w_cyc; rsp0 = n_rsp;
    do_cmd(1, 32'h3, 32'h4, lat, resp, rd, ok);
    total++;
    if (lat !== 3) begin bad++; $display("FAIL wr_latency: got %0d want 3", lat); end
    total++;
    if (resp !== 2'd0) begin bad++; $display("FAIL wr_resp: got %0d want 0", resp); end
    total++;
    if (cmd_ready !== 1'b1) begin bad++; $display("FAIL wr_cmd_ready_with_rsp: got %b want 1", cmd_ready); end
    total++;
    if (last_awaddr !== 32'h3 || last_wdata !== 32'h4) begin
      bad++; $display("FAIL wr_addr_data: got %h/%h want 3/4", last_awaddr, last_wdata);
    end
    total++;
    if (last_wstrb !== 4'hF || last_awprot !== 3'b000) begin
      bad++; $display("FAIL wr_strb_prot: got %h/%b want f/000", last_wstrb, last_awprot);
    end
    settle();
    total++;
    if (aw_cyc - awc0 !== 1 || w_cyc - wc0 !== 1) begin
      bad++; $display("FAIL wr_valid_cycles: aw %0d w %0d want 1/1", aw_cyc - awc0, w_cyc - wc0);
    end
    total++;
    if (n_rsp - rsp0 !== 1) begin bad++; $display("FAIL wr_rsp_pulses: got %0d want 1", n_rsp - rsp0); end
  endtask

  task automatic test_read_basic();
    int lat; logic [1:0] resp; logic [31:0] rd; bit ok;
    do_cmd(0, 32'h3, 32'h0, lat, resp, rd, ok);
    total++;
    if (lat !== 3) begin bad++; $display("FAIL rd_latency: got %0d want 3", lat); end
    total++;
    if (resp !== 2'd0 || rd !== 32'h4) begin bad++; $display("FAIL rd_data: got %0d/%h want 0/4", resp, rd); end
    total++;
    if (last_araddr !== 32'h3 || last_arprot !== 3'b000) begin
      bad++; $display("FAIL rd_addr_prot: got %h/%b want 3/000", last_araddr, last_arprot);
    end
  endtask

  task automatic test_round_trip();
    int lat; logic [1:0] resp; logic [31:0] rd, a, d; bit ok;
    a = ($urandom & 32'h0000_FFFC) | 32'h0001_0000;
    d = $urandom;
    do_cmd(1, a, d, lat, resp, rd, ok);
    total++;
    if (rd !== 32'h4) begin bad++; $display("FAIL rt_rdata_hold: got %h want 4", rd); end
    do_cmd(0, a, 32'h0, lat, resp, rd, ok);
    total++;
    if (rd !== d || resp !== 2'd0) begin bad++; $display("FAIL rt_readback: got %h/%0d want %h/0", rd, resp, d); end
  endtask

  task automatic test_error_resp();
    int lat, aw0, ar0; logic [1:0] resp; logic [31:0] rd; bit ok;
    aw0 = n_aw; ar0 = n_ar;
    b_code = 2'd2;
    do_cmd(1, 32'h40, 32'h41, lat, resp, rd, ok);
    b_code = 2'd0;
    total++;
    if (resp !== 2'd2) begin bad++; $display("FAIL err_bresp: got %0d want 2", resp); end
    r_code = 2'd3;
    do_cmd(0, 32'h80, 32'h0, lat, resp, rd, ok);
    r_code = 2'd0;
    total++;
    if (resp !== 2'd3 || rd !== 32'hDEAD_BEEF) begin
      bad++; $display("FAIL err_rresp: got %0d/%h want 3/deadbeef", resp, rd);
    end
    settle();
    total++;
    if (n_aw - aw0 !== 1 || n_ar - ar0 !== 1) begin
      bad++; $display("FAIL err_no_retry: aw %0d ar %0d want 1/1", n_aw - aw0, n_ar - ar0);
    end
  endtask

  task automatic test_aw_delay();
    int lat, awc0, wc0, rsp0; logic [1:0] resp; logic [31:0] rd; bit ok;
    awc0 = aw_cyc; wc0 = w_cyc; rsp0 = n_rsp;
    aw_delay = 3;
    do_cmd(1, 32'h20, 32'h55, lat, resp, rd, ok);
    aw_delay = 0;
    total++;
    if (lat !== 6) begin bad++; $display("FAIL awd_latency: got %0d want 6", lat); end
    settle();
    total++;
    if (aw_cyc - awc0 !== 4 || w_cyc - wc0 !== 1) begin
      bad++; $display("FAIL awd_valid_cycles: aw %0d w %0d want 4/1", aw_cyc - awc0, w_cyc - wc0);
    end
    total++;
    if (bad_bready !== 0) begin bad++; $display("FAIL awd_bready_early: got %0d want 0", bad_bready); end
    total++;
    if (n_rsp - rsp0 !== 1) begin bad++; $display("FAIL awd_rsp_pulses: got %0d want 1", n_rsp - rsp0); end
  endtask

  task automatic test_back_to_back();
    int acc0, aw0, rsp0, k;
    acc0 = n_acc; aw0 = n_aw; rsp0 = n_rsp;
    @(negedge clk);
    cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h10; cmd_wdata = 32'h11;
    k = 0;
    while (n_acc - acc0 < 2 && k < 50) begin @(negedge clk); k++; end
    cmd_valid = 0;
    total++;
    if (n_acc - acc0 !== 2 || acc_rsp !== 1'b1) begin
      bad++; $display("FAIL b2b_second_accept: accepts %0d rsp_at_accept %b want 2/1", n_acc - acc0, acc_rsp);
    end
    k = 0;
    while (n_rsp - rsp0 < 2 && k < 50) begin @(negedge clk); k++; end
    settle();
    total++;
    if (n_aw - aw0 !== 2 || n_acc - acc0 !== 2 || n_rsp - rsp0 !== 2) begin
      bad++; $display("FAIL b2b_count: aw %0d acc %0d rsp %0d want 2/2/2", n_aw - aw0, n_acc - acc0, n_rsp - rsp0);
    end
  endtask

  task automatic test_reset_midflight();
    int lat, rsp0; logic [1:0] resp; logic [31:0] rd; bit ok;
    @(negedge clk);
    cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h30; cmd_wdata = 32'h31;
    @(posedge clk);
    @(negedge clk); cmd_valid = 0;
    @(negedge clk); #1;
    total++;
    if (!(bus.bvalid === 1'b1 && bus.bready === 1'b1)) begin
      bad++; $display("FAIL rst_pre_bvalid_bready: got %b%b want 11", bus.bvalid, bus.bready);
    end
    rsp0 = n_rsp;
    arst_n = 0;
    #1;
    total++;
    if ({bus.awvalid, bus.wvalid, bus.arvalid, bus.bready, bus.rready, rsp_valid} !== 6'b0
        || rsp_resp !== 2'b00 || rsp_rdata !== 32'h0 || bus.awaddr !== 32'h0 || bus.wdata !== 32'h0) begin
      bad++; $display("FAIL rst_async_values: valids %b resp %0d rdata %h awaddr %h wdata %h want all 0",
        {bus.awvalid, bus.wvalid, bus.arvalid, bus.bready, bus.rready, rsp_valid},
        rsp_resp, rsp_rdata, bus.awaddr, bus.wdata);
    end
    repeat (3) @(negedge clk);
    #2 arst_n = 1;
    @(negedge clk); #1;
    total++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || n_rsp !== rsp0) begin
      bad++; $display("FAIL rst_release: cmd_ready %b rsp_valid %b rsp_delta %0d want 1/0/0", cmd_ready, rsp_valid, n_rsp - rsp0);
    end
    do_cmd(0, 32'h3, 32'h0, lat, resp, rd, ok);
    total++;
    if (lat !== 3 || resp !== 2'd0 || rd !== 32'h4) begin
      bad++; $display("FAIL rst_read_after: lat %0d resp %0d rdata %h want 3/0/4", lat, resp, rd);
    end
  endtask

  initial begin
    bus.awready = 0; bus.wready = 0; bus.arready = 0;
    bus.bvalid = 0; bus.bresp = 0; bus.rvalid = 0; bus.rresp = 0; bus.rdata = 0;
    repeat (3) @(negedge clk);
    #2 arst_n = 1;
    test_reset();
    test_write_basic();
    test_read_basic();
    test_round_trip();
    test_error_resp();
    test_aw_delay();
    test_back_to_back();
    test_reset_midflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
